perm_round_fsm: RTL
===================

Name: perm_round_fsm

Overview:
- Sequences one ASCON permutation, either p^a (12 rounds) or p^b (6 rounds), on request from the mode controller.
- Drives the round counter's init/enable inputs and consumes its 4-bit count.
- Produces the per-round constant and a round-valid strobe for the permutation datapath, which applies one round per strobed cycle.
- Reports busy and a one-cycle done pulse upstream.

Parameters:
- PA_ROUNDS, 12, rounds for p^a; must be <= 12.
- PB_ROUNDS, 6, rounds for p^b; must be <= PA_ROUNDS.
- CNT_W, 4, round counter width; must satisfy 2^CNT_W > PA_ROUNDS.

Ports:
- clock_i  in  1  clock; all state updates on rising edge.
- resetb_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request a permutation; sampled only in IDLE.
- mode_i  in  1  0 = p^a (PA_ROUNDS), 1 = p^b (PB_ROUNDS); latched with start.
- round_i  in  CNT_W  current count from the round counter.
- counter_init_o  out  1  synchronous clear request to the round counter.
- counter_en_o  out  1  increment request to the round counter.
- round_valid_o  out  1  datapath applies one round this cycle.
- round_const_o  out  8  ASCON round constant for this cycle.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the last round has been applied.
- err_o  out  1  sequence error flag; see Optional Feature.

Behaviour:
- Counter contract: round_i clears the cycle after counter_init_o is high, and increments by exactly 1 per cycle with counter_en_o high.
- Reset (async, resetb_i low):
  - State goes to IDLE; mode_q = 0; err_o = 0.
  - All outputs 0; round_const_o = 8'h00.
  - A reset mid-operation abandons the run. No done_o is issued.
- States:
  - IDLE: outputs 0. If start_i = 1: latch mode_q <= mode_i, go to INIT. Otherwise stay.
  - INIT (1 cycle): counter_init_o = 1, busy_o = 1. Go to ROUND.
  - ROUND: busy_o = 1, counter_en_o = 1, round_valid_o = 1. Let n = mode_q ? PB_ROUNDS : PA_ROUNDS.
    - If round_i == n-1: go to DONE.
    - Otherwise stay.
  - DONE (1 cycle): done_o = 1, busy_o = 1, counter_en_o = 0. Go to IDLE.
- Round constant:
  - Index k = round_i + (12 - n), 4-bit unsigned.
  - round_const_o = {4'hF - k, k}, valid only while round_valid_o = 1; 8'h00 otherwise.
  - p^a sequence: F0 E1 D2 C3 B4 A5 96 87 78 69 5A 4B.
  - p^b sequence: 96 87 78 69 5A 4B.
- Latency:
  - start accepted at cycle 0; INIT at cycle 1; ROUND at cycles 2..n+1; done_o at cycle n+2.
  - Earliest next start accepted at cycle n+3.
- Boundaries:
  - start_i while busy: ignored, not queued.
  - start_i held high through DONE: a new run starts in the first IDLE cycle.
  - mode_i changing mid-run: no effect.
  - round_i > n-1 in ROUND (counter fault): treated as last round, go to DONE. Never loop past 12.
  - round_const_o must never be indexed beyond k = 11; clamp k to 11.

Optional Feature:
- Macro: PERM_ROUND_CHECK_EN.
- Defined:
  - A shadow count, reset in INIT and incremented each ROUND cycle, is compared with round_i in every ROUND cycle.
  - Any mismatch sets err_o. err_o is sticky until reset or the next accepted start.
  - Exit from ROUND is then taken from the shadow count, so a stuck or double-stepping counter cannot stretch or shorten the permutation.
- Not defined: err_o tied to 0; no shadow register; exit decided by round_i only.

Decomposition:
- Package ascon_pkg:
  - Typedef perm_state_t {IDLE, INIT, ROUND, DONE}.
  - Localparams PA_ROUNDS_C = 12, PB_ROUNDS_C = 6, ROUND_CNT_W_C = 4.
  - Function round_const(k) returning {4'hF-k, k}.
  - Typedef perm_mode_t {MODE_PA, MODE_PB}.
- Sub-module: one natural split, perm_round_const (combinational: round_i, mode → constant with clamp). Reused by the datapath testbench model.
- FSM and handshake stay in perm_round_fsm.

Test Plan:
- p^a run: start_i = 1, mode_i = 0 with an ideal counter model → round_valid_o high 12 cycles with constants F0..4B in order; done_o pulses at cycle 14.
- p^b run: mode_i = 1 → 6 strobes with constants 96,87,78,69,5A,4B; done_o at cycle 8; counter_init_o exactly at cycle 1.
- Start while busy: pulse start_i at cycles 4 and 6 of a p^a run → ignored; exactly one done_o. Start held high through DONE → second run's INIT at cycle 16.
- Reset mid-run: assert resetb_i low at ROUND cycle 5 → all outputs 0 immediately, no done_o; a fresh start afterwards yields the full F0..4B sequence.
- Counter fault (PERM_ROUND_CHECK_EN defined): round_i held at 3 → err_o set at the first mismatch; done_o still at cycle 14; err_o cleared by the next start.
- Counter fault without macro: round_i forced to 13 in ROUND → DONE next cycle; round_const_o never exceeds index 11 (4B); err_o stays 0.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types, default sizes and the round-constant helper for the ASCON permutation sequencer.
package ascon_pkg;

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} perm_state_t;

  typedef enum logic {MODE_PA, MODE_PB} perm_mode_t;

  localparam int PA_ROUNDS_C    = 12;
  localparam int PB_ROUNDS_C    = 6;
  localparam int ROUND_CNT_W_C  = 4;

  // Constant for round index k: high nibble counts down while low nibble counts up.
  function automatic logic [7:0] round_const(input logic [3:0] k);
    return {4'hF - k, k};
  endfunction

endpackage

// File: rtl/perm_round_const.sv
// Maps the round counter value and permutation mode to the ASCON round constant,
// aligning p^b to the tail of the p^a schedule and clamping the index at 11.
module perm_round_const
  import ascon_pkg::*;
#(
  parameter int PA_ROUNDS = PA_ROUNDS_C,
  parameter int PB_ROUNDS = PB_ROUNDS_C,
  parameter int CNT_W     = ROUND_CNT_W_C
) (
  input  logic [CNT_W-1:0] round,
  input  logic             mode_pb,
  output logic [7:0]       rc
);

  // Wide enough that round + 12 can never wrap, so a faulty counter is always clamped.
  localparam int KW = ((CNT_W > 4) ? CNT_W : 4) + 1;

  logic [KW-1:0] offset;
  logic [KW-1:0] k_wide;
  logic [3:0]    k;

  always_comb begin
    offset = mode_pb ? KW'(12 - PB_ROUNDS) : KW'(12 - PA_ROUNDS);
    k_wide = KW'(round) + offset;
    if (k_wide > KW'(11)) begin
      k = 4'd11;
    end else begin
      k = k_wide[3:0];
    end
    rc = ascon_pkg::round_const(k);
  end

endmodule

// File: rtl/perm_round_fsm.sv
// Sequences one ASCON p^a or p^b permutation against an external round counter.
// Define PERM_ROUND_CHECK_EN to add a shadow count that flags counter faults and owns the exit.
module perm_round_fsm
  import ascon_pkg::*;
#(
  parameter int PA_ROUNDS = PA_ROUNDS_C,
  parameter int PB_ROUNDS = PB_ROUNDS_C,
  parameter int CNT_W     = ROUND_CNT_W_C
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] round_i,
  output logic             counter_init_o,
  output logic             counter_en_o,
  output logic             round_valid_o,
  output logic [7:0]       round_const_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  perm_state_t      state_q;
  perm_state_t      state_d;
  perm_mode_t       mode_q;
  logic [CNT_W-1:0] last_round;
  logic             last_hit;
  logic             accept;
  logic [7:0]       rc;

  assign accept     = (state_q == IDLE) && start_i;
  assign last_round = (mode_q == MODE_PB) ? CNT_W'(PB_ROUNDS - 1) : CNT_W'(PA_ROUNDS - 1);

  perm_round_const #(
    .PA_ROUNDS (PA_ROUNDS),
    .PB_ROUNDS (PB_ROUNDS),
    .CNT_W     (CNT_W)
  ) u_round_const (
    .round   (round_i),
    .mode_pb (mode_q == MODE_PB),
    .rc      (rc)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      mode_q  <= MODE_PA;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= perm_mode_t'(mode_i);
      end
    end
  end

`ifdef PERM_ROUND_CHECK_EN
  logic [CNT_W-1:0] shadow_q;
  logic             err_q;

  // The shadow count tracks the ideal counter; any divergence is latched until the next run.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
      end
      if (state_q == INIT) begin
        shadow_q <= '0;
      end else if (state_q == ROUND) begin
        shadow_q <= shadow_q + CNT_W'(1);
        if (shadow_q != round_i) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign last_hit = (shadow_q >= last_round);
  assign err_o    = err_q;
`else
  // A counter at or past the last index ends the run, so a runaway counter cannot loop.
  assign last_hit = (round_i >= last_round);
  assign err_o    = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    counter_init_o = 1'b0;
    counter_en_o   = 1'b0;
    round_valid_o  = 1'b0;
    round_const_o  = 8'h00;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = INIT;
        end
      end
      INIT: begin
        counter_init_o = 1'b1;
        busy_o         = 1'b1;
        state_d        = ROUND;
      end
      ROUND: begin
        busy_o        = 1'b1;
        counter_en_o  = 1'b1;
        round_valid_o = 1'b1;
        round_const_o = rc;
        if (last_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
